// File: rtl/stdp_weight_update_if.sv
// Handshake and weight-memory bus for stdp_weight_update.
// master = column controller / memory side, slave = the STDP update engine.
interface stdp_weight_update_if #(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_INPUTS  = 8,
  parameter int TIME_W      = 4,
  parameter int W_W         = 3
);
  localparam int NW = $clog2(NUM_NEURONS);
  localparam int AW = $clog2(NUM_NEURONS * NUM_INPUTS);

  logic                         start;
  logic [NW-1:0]                winning_neuron;
  logic [TIME_W-1:0]            output_spike_time;
  logic [NUM_INPUTS*TIME_W-1:0] input_spike_times;
  logic                         busy;
  logic                         done;
  logic [AW-1:0]                wt_addr;
  logic                         wt_rd_en;
  logic [W_W-1:0]               wt_rd_data;
  logic                         wt_wr_en;
  logic [W_W-1:0]               wt_wr_data;

  modport master (
    output start, winning_neuron, output_spike_time, input_spike_times, wt_rd_data,
    input  busy, done, wt_addr, wt_rd_en, wt_wr_en, wt_wr_data
  );

  modport slave (
    input  start, winning_neuron, output_spike_time, input_spike_times, wt_rd_data,
    output busy, done, wt_addr, wt_rd_en, wt_wr_en, wt_wr_data
  );
endinterface

// File: rtl/stdp_weight_update.sv
// STDP weight update for the winning neuron: read-calc-write sweep over its synapses.
// Optional macro STDP_STOCHASTIC_EN gates each update with a 3/4-probability LFSR draw.
module stdp_weight_update #(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_INPUTS  = 8,
  parameter int TIME_W      = 4,
  parameter int W_W         = 3
) (
  input logic                 clk,
  input logic                 rst_l,
  stdp_weight_update_if.slave bus
);
  localparam int NW = $clog2(NUM_NEURONS);
  localparam int AW = $clog2(NUM_NEURONS * NUM_INPUTS);
  localparam int IW = $clog2(NUM_INPUTS);
  localparam logic [W_W-1:0]    WMAX     = '1;
  localparam logic [TIME_W-1:0] NO_SPIKE = '1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CALC, S_WRITE, S_DONE} state_t;

  state_t                       state_q;
  logic [IW-1:0]                idx_q, idx_d;
  logic [NW-1:0]                winner_q;
  logic [TIME_W-1:0]            t_out_q;
  logic [NUM_INPUTS*TIME_W-1:0] t_in_q;
  logic                         busy_q, done_q, rd_en_q, wr_en_q;
  logic [AW-1:0]                addr_q;
  logic [W_W-1:0]               wr_data_q;

  logic [TIME_W-1:0] t_in;
  logic [W_W:0]      w_ext, w_inc, w_dec;
  logic [W_W-1:0]    w_new_d;
  logic              apply;

  function automatic logic [AW-1:0] addr_of(input logic [NW-1:0] w, input logic [IW-1:0] i);
    return AW'(w) * AW'(NUM_INPUTS) + AW'(i);
  endfunction

`ifdef STDP_STOCHASTIC_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11; advances once per weight calculation.
  always_ff @(posedge clk) begin
    if (!rst_l)                lfsr_q <= 16'hACE1;
    else if (state_q == S_CALC) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign apply = (lfsr_q[1:0] != 2'b00);
`else
  assign apply = 1'b1;
`endif

  // Saturating update computed one bit wider than the weight so nothing wraps.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_new_d = bus.wt_rd_data;
    idx_d   = idx_q + 1'b1;
    t_in    = t_in_q[idx_q*TIME_W +: TIME_W];
    w_ext   = {1'b0, bus.wt_rd_data};
    w_inc   = (w_ext == {1'b0, WMAX}) ? w_ext : w_ext + 1'b1;
    w_dec   = (w_ext == '0) ? w_ext : w_ext - 1'b1;
    if (apply && t_out_q != NO_SPIKE) begin
      if (t_in == NO_SPIKE || t_in > t_out_q) w_new_d = w_dec[W_W-1:0];
      else                                     w_new_d = w_inc[W_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset clears the captured times too, so a stale sweep can never resume.
    if (!rst_l) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      winner_q  <= '0;
      t_out_q   <= '0;
      t_in_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            winner_q <= bus.winning_neuron;
            t_out_q  <= bus.output_spike_time;
            t_in_q   <= bus.input_spike_times;
            idx_q    <= '0;
            addr_q   <= addr_of(bus.winning_neuron, '0);
            rd_en_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_READ;
          end
        end
        S_READ: begin
          rd_en_q <= 1'b0;
          state_q <= S_CALC;
        end
        S_CALC: begin
          wr_data_q <= w_new_d;
          wr_en_q   <= 1'b1;
          state_q   <= S_WRITE;
        end
        S_WRITE: begin
          wr_en_q <= 1'b0;
          if (idx_q == IW'(NUM_INPUTS - 1)) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_d;
            addr_q  <= addr_of(winner_q, idx_d);
            rd_en_q <= 1'b1;
            state_q <= S_READ;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.wt_addr    = addr_q;
  assign bus.wt_rd_en   = rd_en_q;
  assign bus.wt_wr_en   = wr_en_q;
  assign bus.wt_wr_data = wr_data_q;
endmodule

// File: tb/tb_stdp_weight_update.sv
// Scoreboard bench for stdp_weight_update: expected writes are queued at start and
// popped as the DUT writes into the bench's 1-cycle-latency weight memory.
module tb_stdp_weight_update;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic [4:0] addr;
    logic [2:0] data;
    logic [2:0] old;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] mem [32];

  stdp_weight_update_if #(.NUM_NEURONS(4), .NUM_INPUTS(8), .TIME_W(4), .W_W(3)) bus ();

  stdp_weight_update dut (.clk(clk), .rst_l(rst_l), .bus(bus));

  always #5 clk = ~clk;

  // Weight memory: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.wt_rd_en) bus.wt_rd_data <= mem[bus.wt_addr];
    if (bus.wt_wr_en) mem[bus.wt_addr] <= bus.wt_wr_data;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, sim time=%0t required=<400000", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] rule(input logic [3:0] t_in, input logic [3:0] t_out, input logic [2:0] w);
    if (t_out == 4'hF) return w;
    if (t_in == 4'hF || t_in > t_out) return (w == 3'd0) ? 3'd0 : w - 3'd1;
    return (w == 3'd7) ? 3'd7 : w + 3'd1;
  endfunction

  function automatic logic [31:0] pack(input logic [3:0] t [8]);
    logic [31:0] v = '0;
    for (int i = 0; i < 8; i++) v[i*4 +: 4] = t[i];
    return v;
  endfunction

  // Drives one sweep and consumes the scoreboard as writes appear.
  // inject_cycle > 0 pulses a competing start; abort_cycle > 0 resets mid-sweep.
  task automatic run_sweep(input logic [1:0] winner, input logic [3:0] t_out, input logic [31:0] times,
                           input int inject_cycle, input int abort_cycle);
    int done_cnt = 0;
    int lo = winner * 8;
    int hi = winner * 8 + 7;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.addr = 5'(lo + i);
      e.old  = mem[lo + i];
      e.data = rule(times[i*4 +: 4], t_out, e.old);
      e.cyc  = 3 + 3 * i;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.winning_neuron = winner;
    bus.output_spike_time = t_out;
    bus.input_spike_times = times;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      checks++;
      if (bus.wt_rd_en && bus.wt_wr_en) begin
        failures++;
        $display("FAIL rd_wr_overlap: cycle %0d rd_en=%0b wr_en=%0b, required not both high", cyc, bus.wt_rd_en, bus.wt_wr_en);
      end
      if (bus.wt_rd_en || bus.wt_wr_en) begin
        checks++;
        if (int'(bus.wt_addr) < lo || int'(bus.wt_addr) > hi) begin
          failures++;
          $display("FAIL addr_range: cycle %0d addr=%0d, required %0d..%0d", cyc, bus.wt_addr, lo, hi);
        end
      end
      if (bus.wt_wr_en) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL extra_write: cycle %0d addr=%0d data=%0d, required no write", cyc, bus.wt_addr, bus.wt_wr_data);
        end else begin
          e = sb.pop_front();
          if (bus.wt_addr !== e.addr) begin
            failures++;
            $display("FAIL write_addr: cycle %0d addr=%0d, required %0d", cyc, bus.wt_addr, e.addr);
          end
`ifdef STDP_STOCHASTIC_EN
          if (bus.wt_wr_data !== e.data && bus.wt_wr_data !== e.old) begin
`else
          if (bus.wt_wr_data !== e.data) begin
`endif
            failures++;
            $display("FAIL write_data: addr %0d data=%0d, required %0d", e.addr, bus.wt_wr_data, e.data);
          end
          if (cyc !== e.cyc) begin
            failures++;
            $display("FAIL write_cycle: addr %0d at cycle %0d, required %0d", e.addr, cyc, e.cyc);
          end
        end
      end
      if (bus.done) begin
        done_cnt++;
        checks++;
        if (cyc !== 25 || bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL done_timing: done at cycle %0d busy=%0b, required cycle 25 busy=1", cyc, bus.busy);
        end
      end
      if (cyc == inject_cycle) begin
        bus.start = 1'b1;
        bus.winning_neuron = ~winner;
        bus.output_spike_time = 4'd0;
        bus.input_spike_times = '0;
      end
      if (cyc == abort_cycle) begin
        rst_l = 1'b0;
        break;
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
    if (abort_cycle > 0) begin
      sb.delete();
      repeat (2) @(negedge clk);
      rst_l = 1'b1;
      for (int k = 0; k < 20; k++) begin
        checks++;
        if (bus.wt_wr_en !== 1'b0 || bus.wt_rd_en !== 1'b0 || bus.busy !== 1'b0) begin
          failures++;
          $display("FAIL post_abort: wr_en=%0b rd_en=%0b busy=%0b, required 0 0 0", bus.wt_wr_en, bus.wt_rd_en, bus.busy);
        end
        @(negedge clk);
      end
    end else begin
      checks++;
      if (done_cnt !== 1 || sb.size() !== 0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL sweep_end: done pulses=%0d pending writes=%0d busy=%0b, required 1 0 0", done_cnt, sb.size(), bus.busy);
      end
    end
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.wt_rd_en, bus.wt_wr_en} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_idle: busy/done/rd/wr=%b, required 0000", {bus.busy, bus.done, bus.wt_rd_en, bus.wt_wr_en});
      end
    end
    checks++;
    if (bus.wt_addr !== 5'd0 || bus.wt_wr_data !== 3'd0) begin
      failures++;
      $display("FAIL reset_bus: addr=%0d wr_data=%0d, required 0 0", bus.wt_addr, bus.wt_wr_data);
    end
  endtask

  task automatic test_rules();
    logic [3:0] t [8] = '{4'd3, 4'd5, 4'd6, 4'd15, 4'd0, 4'd9, 4'd15, 4'd5};
    logic [2:0] want [8] = '{3'd5, 3'd5, 3'd3, 3'd3, 3'd5, 3'd3, 3'd3, 3'd5};
    for (int i = 0; i < 32; i++) mem[i] = 3'd4;
    run_sweep(2'd2, 4'd5, pack(t), 0, 0);
`ifndef STDP_STOCHASTIC_EN
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[16 + i] !== want[i]) begin
        failures++;
        $display("FAIL rules_mem: addr %0d holds %0d, required %0d", 16 + i, mem[16 + i], want[i]);
      end
    end
`endif
  endtask

  task automatic test_saturation();
    logic [3:0] t [8] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd15, 4'd15, 4'd15, 4'd15};
    for (int i = 0; i < 8; i++) mem[i] = (i < 4) ? 3'd7 : 3'd0;
    run_sweep(2'd0, 4'd10, pack(t), 0, 0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[i] !== ((i < 4) ? 3'd7 : 3'd0)) begin
        failures++;
        $display("FAIL saturation_mem: addr %0d holds %0d, required %0d", i, mem[i], (i < 4) ? 7 : 0);
      end
    end
  endtask

  task automatic test_no_spike();
    logic [3:0] t [8] = '{4'd0, 4'd15, 4'd3, 4'd14, 4'd7, 4'd15, 4'd1, 4'd9};
    for (int i = 0; i < 8; i++) mem[8 + i] = 3'((i + 1) % 8);
    run_sweep(2'd1, 4'd15, pack(t), 0, 0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[8 + i] !== 3'((i + 1) % 8)) begin
        failures++;
        $display("FAIL no_spike_mem: addr %0d holds %0d, required %0d", 8 + i, mem[8 + i], (i + 1) % 8);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [3:0] t [8] = '{4'd2, 4'd12, 4'd15, 4'd4, 4'd4, 4'd5, 4'd0, 4'd15};
    for (int i = 0; i < 32; i++) mem[i] = 3'd3;
    run_sweep(2'd3, 4'd4, pack(t), 5, 0);
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (mem[i] !== 3'd3) begin
        failures++;
        $display("FAIL busy_ignore_mem: addr %0d holds %0d, required 3", i, mem[i]);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [3:0] t [8] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
    for (int i = 0; i < 8; i++) mem[8 + i] = 3'd3;
    run_sweep(2'd1, 4'd8, pack(t), 0, 10);
`ifndef STDP_STOCHASTIC_EN
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[8 + i] !== ((i < 3) ? 3'd4 : 3'd3)) begin
        failures++;
        $display("FAIL abort_mem: addr %0d holds %0d, required %0d", 8 + i, mem[8 + i], (i < 3) ? 4 : 3);
      end
    end
    run_sweep(2'd1, 4'd8, pack(t), 0, 0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[8 + i] !== ((i < 3) ? 3'd5 : 3'd4)) begin
        failures++;
        $display("FAIL rerun_mem: addr %0d holds %0d, required %0d", 8 + i, mem[8 + i], (i < 3) ? 5 : 4);
      end
    end
`else
    run_sweep(2'd1, 4'd8, pack(t), 0, 0);
`endif
  endtask

  initial begin
    bus.start = 1'b0;
    bus.winning_neuron = '0;
    bus.output_spike_time = '0;
    bus.input_spike_times = '0;
    bus.wt_rd_data = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    test_reset();
    test_rules();
    test_saturation();
    test_no_spike();
    test_start_while_busy();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
